// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 16-bit RAM, with
// bounded burst locking and registered per-port read-valid.
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t        owner_reg, owner_next;
  logic          last_reg, last_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [15:0]   ram_addr_reg, ram_addr_next;
  logic [1:0]    rd_pend_reg, rd_pend_next;

  logic [1:0]    req;
  logic [1:0]    we;
  logic [1:0]    lock;
  logic [15:0]   addr  [2];
  logic [15:0]   wdata [2];

  logic [1:0]    owns;
  logic [1:0]    keep;
  logic [1:0]    gnt;
  logic          gnt_any;
  logic          gnt_sel;
  logic          burst_under;

  assign req      = {req1, req0};
  assign we       = {we1, we0};
  assign lock     = {lock1, lock0};
  assign addr[0]  = addr0;
  assign addr[1]  = addr1;
  assign wdata[0] = wdata0;
  assign wdata[1] = wdata1;

  assign burst_under = (burst_cnt_reg < CW'(MAX_BURST));

  // An owner keeps the RAM while it still requests, unless its burst budget is
  // spent and the other port is waiting.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam owner_t MINE  = (gi == 0) ? OWN_P0 : OWN_P1;
      localparam int     OTHER = 1 - gi;

      assign owns[gi]         = (owner_reg == MINE);
      assign keep[gi]         = owns[gi] & req[gi] & (burst_under | ~req[OTHER]);
      assign rd_pend_next[gi] = gnt[gi] & ~we[gi];
    end
  endgenerate

  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    if (!rst) begin
      gnt_any = 1'b0;
    end else if (keep[0]) begin
      gnt_any = 1'b1;
      gnt_sel = 1'b0;
    end else if (keep[1]) begin
      gnt_any = 1'b1;
      gnt_sel = 1'b1;
    end else if (req[0] ^ req[1]) begin
      gnt_any = 1'b1;
      gnt_sel = req[1];
    end else if (req[0] & req[1]) begin
      gnt_any = 1'b1;
      gnt_sel = ~last_reg;
    end
  end

  assign gnt  = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Any cycle without a locking grant (including an idle cycle after the owner
  // drops its request) releases ownership.
  always_comb begin
    owner_next     = OWN_NONE;
    burst_cnt_next = '0;
    last_next      = last_reg;
    ram_addr_next  = ram_addr_reg;
    if (gnt_any) begin
      last_next     = gnt_sel;
      ram_addr_next = addr[gnt_sel];
      if (lock[gnt_sel]) begin
        owner_next = gnt_sel ? OWN_P1 : OWN_P0;
        if (owns[gnt_sel]) begin
          burst_cnt_next = burst_under ? burst_cnt_reg + 1'b1 : burst_cnt_reg;
        end else begin
          burst_cnt_next = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg     <= OWN_NONE;
      last_reg      <= 1'b1;
      burst_cnt_reg <= '0;
      ram_addr_reg  <= '0;
      rd_pend_reg   <= '0;
    end else begin
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
      ram_addr_reg  <= ram_addr_next;
      rd_pend_reg   <= rd_pend_next;
    end
  end

  // Address holds its last granted value on idle cycles so the RAM sees no toggling.
  assign ram_addr  = gnt_any ? addr[gnt_sel] : ram_addr_reg;
  assign ram_we    = gnt_any & we[gnt_sel];
  assign ram_wdata = wdata[gnt_sel];

  assign rvalid0 = rd_pend_reg[0];
  assign rvalid1 = rd_pend_reg[1];
  assign rdata0  = ram_rdata;
  assign rdata1  = ram_rdata;

endmodule
